// File: rtl/fnd_scan_cntr.sv
// Time-multiplexed N-digit common-anode 7-segment driver with shadowed load and per-digit dp.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppresses leading zero digits above digit 0).
module fnd_scan_cntr #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic                  busy,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     com
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   val_q, val_d;
    logic [DIGITS-1:0]     dp_q, dp_d;
    logic                  busy_q, busy_d;
    logic [3:0]            slot_nib_q, slot_nib_d;
    logic                  slot_dp_q, slot_dp_d;
    logic                  slot_blank_q, slot_blank_d;
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     com_q, com_d;

    logic                  wrap;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  lz_blank;
    logic                  lz_run;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Digit data for the slot being entered, selected by the current index.
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = val_q[i*4 +: 4];
                cur_dp  = dp_q[i];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_blank = 1'b0;
        lz_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_run = lz_run & (val_q[i*4 +: 4] == 4'h0);
            if ((idx_q == IDX_W'(i)) && lz_run && !dp_q[i])
                lz_blank = 1'b1;
        end
    end
`else
    always_comb begin
        lz_run   = 1'b0;
        lz_blank = 1'b0;
    end
`endif

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        val_d        = val_q;
        dp_d         = dp_q;
        busy_d       = load;
        slot_nib_d   = slot_nib_q;
        slot_dp_d    = slot_dp_q;
        slot_blank_d = slot_blank_q;
        seg_d        = 8'hFF;
        com_d        = '1;

        if (load) begin
            val_d = value;
            dp_d  = dp_in;
        end

        wrap = (cnt_q == CNT_W'(SCAN_DIV - 1));
        if (wrap) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // The blank cycle snapshots the digit so a load cannot change a lit slot.
        if (cnt_q == '0) begin
            slot_nib_d   = cur_nib;
            slot_dp_d    = cur_dp;
            slot_blank_d = lz_blank;
        end else begin
            for (int i = 0; i < DIGITS; i++)
                com_d[i] = (idx_q != IDX_W'(i));
            seg_d = slot_blank_q ? 8'hFF : {~slot_dp_q, hex7(slot_nib_q)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            val_q        <= '0;
            dp_q         <= '0;
            busy_q       <= 1'b0;
            slot_nib_q   <= 4'h0;
            slot_dp_q    <= 1'b0;
            slot_blank_q <= 1'b0;
            seg_q        <= 8'hFF;
            com_q        <= '1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            val_q        <= val_d;
            dp_q         <= dp_d;
            busy_q       <= busy_d;
            slot_nib_q   <= slot_nib_d;
            slot_dp_q    <= slot_dp_d;
            slot_blank_q <= slot_blank_d;
            seg_q        <= seg_d;
            com_q        <= com_d;
        end
    end

    assign busy = busy_q;
    assign seg  = seg_q;
    assign com  = com_q;

endmodule

// File: tb/tb_fnd_scan_cntr.sv
// Bench for fnd_scan_cntr: 4 digits, 4-cycle slots; expected pins come from a hand-filled vector table.
module tb_fnd_scan_cntr;

    localparam int D = 4;
    localparam int S = 4;

    logic          clk = 1'b0;
    logic          reset_p;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic          load;
    logic          busy;
    logic [7:0]    seg;
    logic [3:0]    com;

    fnd_scan_cntr #(.DIGITS(D), .SCAN_DIV(S), .CNT_W(3)) dut (
        .clk(clk), .reset_p(reset_p), .value(value), .dp_in(dp_in),
        .load(load), .busy(busy), .seg(seg), .com(com)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      value;
        logic [3:0]       dp;
        logic [3:0][7:0]  exp_seg;   // [i] = full seg pattern expected for digit i
    } vec_t;

    typedef struct {
        logic [7:0] seg;
        logic [3:0] com;
        logic       busy;
    } exp_t;

    localparam int NV = 7;
    vec_t vecs [NV];
    exp_t sb [$];

    int errors = 0;
    int checks = 0;
    int m;          // non-reset edges since last reset
    int cur_vec;    // vector currently in the shadow registers
    int slot_vec;   // vector captured for the slot on the pins

    task automatic step(input bit rst, input bit ld, input int vi);
        exp_t e, g;
        int cnt, idx;
        reset_p = rst;
        load    = ld;
        value   = vecs[vi].value;
        dp_in   = vecs[vi].dp;
        if (rst) begin
            e = '{8'hFF, 4'hF, 1'b0};
            m = 0; cur_vec = 0; slot_vec = 0;
        end else begin
            cnt = m % S;
            idx = (m / S) % D;
            if (cnt == 0) begin
                slot_vec = cur_vec;
                e.seg = 8'hFF;
                e.com = 4'hF;
            end else begin
                e.seg = vecs[slot_vec].exp_seg[idx];
                e.com = ~(4'b0001 << idx);
            end
            e.busy = ld;
            if (ld) cur_vec = vi;
            m++;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        checks += 3;
        if (seg !== g.seg) begin
            errors++;
            $display("FAIL seg t=%0t: got %h want %h", $time, seg, g.seg);
        end
        if (com !== g.com) begin
            errors++;
            $display("FAIL com t=%0t: got %b want %b", $time, com, g.com);
        end
        if (busy !== g.busy) begin
            errors++;
            $display("FAIL busy t=%0t: got %b want %b", $time, busy, g.busy);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0);
    endtask

    initial begin
        vecs[0] = '{16'h0000, 4'b0000, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        vecs[1] = '{16'h1234, 4'b0100, {8'hF9, 8'h24, 8'hB0, 8'h99}};
        vecs[2] = '{16'hBEEF, 4'b0000, {8'h83, 8'h86, 8'h86, 8'h8E}};
        vecs[3] = '{16'hAAAA, 4'b1111, {8'h08, 8'h08, 8'h08, 8'h08}};
        vecs[4] = '{16'h5678, 4'b0001, {8'h92, 8'h82, 8'hF8, 8'h00}};
        vecs[5] = '{16'h9CD0, 4'b1000, {8'h10, 8'hC6, 8'hA1, 8'hC0}};
`ifdef LEADING_ZERO_BLANK_EN
        vecs[6] = '{16'h0070, 4'b0000, {8'hFF, 8'hFF, 8'hF8, 8'hC0}};
`else
        vecs[6] = '{16'h0070, 4'b0000, {8'hC0, 8'hC0, 8'hF8, 8'hC0}};
`endif
        reset_p = 1'b1; load = 1'b0; value = '0; dp_in = '0;
        m = 0; cur_vec = 0; slot_vec = 0;

        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 0);
        idle(2 * S * D);

        // Table: load each vector at a varying phase, then watch two full scans.
        for (int i = 1; i < NV; i++) begin
            idle((i * 3) % 7);
            step(1'b0, 1'b1, i);
            idle(2 * S * D);
        end

        // Load landing exactly on a prescaler wrap.
        while ((m % S) != S - 1) step(1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1);
        idle(S * D + 2);

        // Back-to-back loads: second one wins, busy stays high two cycles.
        step(1'b0, 1'b1, 3);
        step(1'b0, 1'b1, 2);
        idle(2 * S * D);

        // Reset while digit 2 is lit.
        while (!(((m / S) % D) == 2 && (m % S) == 2)) step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        idle(S * D + 2);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d entries want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
